// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin shares one UART tx line among NUM_REQ requesters; frame = start, 7 data (LSB first), even parity, stop
//   i_clk       system clock, posedge
//   i_rst_n     asynchronous active-low reset
//   i_req       per-requester transmit request (level)
//   i_data_in   requester k's word at [k*DATA_W +: DATA_W]
//   o_ack       one-cycle pulse: word k accepted
//   o_tx_line   serial output, idles high
//   o_busy      high while a frame is on o_tx_line
//   o_grant_id  index of the requester owning the current or most recent frame
module uart_tx_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 7,
  parameter int CLKS_PER_BIT = 1736,
  parameter int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*DATA_W-1:0] i_data_in,
  output logic [NUM_REQ-1:0]        o_ack,
  output logic                      o_tx_line,
  output logic                      o_busy,
  output logic [ID_W-1:0]           o_grant_id
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  state_t              r_state, w_state;
  logic [CW-1:0]       r_cnt, w_cnt;
  logic [2:0]          r_idx, w_idx;
  logic [DATA_W-1:0]   r_shift, w_shift, w_word;
  logic [DATA_W-1:0]   w_words [NUM_REQ];
  logic                r_par, w_par, r_tx, w_tx, r_busy, w_busy, w_tick;
  logic [ID_W-1:0]     r_ptr, w_ptr, r_gid, w_gid, w_win, w_k;
  logic [NUM_REQ-1:0]  r_ack, w_ack;
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_w
    assign w_words[g] = i_data_in[g*DATA_W +: DATA_W];
  end
  // descending scan so the requester closest after the pointer wins last
  always_comb begin
    w_win = '0;
    w_k   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_k = ID_W'((int'(r_ptr) + 1 + i) % NUM_REQ);
      if (i_req[w_k]) w_win = w_k;
    end
  end
  assign w_word = w_words[w_win];
  assign w_tick = r_cnt == CW'(CLKS_PER_BIT - 1);
  always_comb begin
    w_state = r_state;
    w_cnt   = w_tick ? '0 : r_cnt + 1'b1;
    w_idx   = r_idx;
    w_shift = r_shift;
    w_par   = r_par;
    w_ptr   = r_ptr;
    w_gid   = r_gid;
    w_ack   = '0;
    w_tx    = r_tx;
    w_busy  = r_busy;
    case (r_state)
      S_IDLE: begin
        w_cnt = '0;
        if (|i_req) begin
          w_ack   = NUM_REQ'(1) << w_win;
          w_gid   = w_win;
          w_ptr   = w_win;
          w_shift = w_word;
          w_par   = ^w_word;
          w_idx   = '0;
          w_tx    = 1'b0;
          w_busy  = 1'b1;
          w_state = S_START;
        end
      end
      S_START: if (w_tick) begin
        w_state = S_DATA;
        w_tx    = r_shift[0];
      end
      S_DATA: if (w_tick) begin
        if (r_idx == 3'(DATA_W - 1)) begin
          w_state = S_PARITY;
          w_tx    = r_par;
        end else begin
          w_idx   = r_idx + 3'd1;
          w_shift = r_shift >> 1;
          w_tx    = r_shift[1];
        end
      end
      S_PARITY: if (w_tick) begin
        w_state = S_STOP;
        w_tx    = 1'b1;
      end
      S_STOP: if (w_tick) begin
        w_state = S_IDLE;
        w_busy  = 1'b0;
        w_tx    = 1'b1;
      end
      default: w_state = S_IDLE;
    endcase
  end
  // pointer resets to the last index so requester 0 is searched first
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_ptr   <= ID_W'(NUM_REQ - 1);
      r_gid   <= '0;
      r_ack   <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_idx   <= w_idx;
      r_shift <= w_shift;
      r_par   <= w_par;
      r_ptr   <= w_ptr;
      r_gid   <= w_gid;
      r_ack   <= w_ack;
      r_tx    <= w_tx;
      r_busy  <= w_busy;
    end
  end
  assign o_ack      = r_ack;
  assign o_tx_line  = r_tx;
  assign o_busy     = r_busy;
  assign o_grant_id = r_gid;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed table-driven bench for uart_tx_scheduler with CLKS_PER_BIT=4, NUM_REQ=4
module tb_uart_tx_scheduler;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [27:0] data_in = '0;
  logic [3:0]  ack;
  logic        tx_line, busy;
  logic [1:0]  grant_id;
  int          total = 0, bad = 0;
  typedef struct {
    bit         rst;
    logic [3:0] raise;
    logic [27:0] data;
    logic [1:0] gid;
    logic [6:0] word;
  } vec_t;
  vec_t tbl [11];
  uart_tx_scheduler #(.NUM_REQ(4), .DATA_W(7), .CLKS_PER_BIT(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_data_in(data_in),
    .o_ack(ack), .o_tx_line(tx_line), .o_busy(busy), .o_grant_id(grant_id)
  );
  always #5 clk = ~clk;
  function automatic logic [27:0] pack(input logic [6:0] a3, a2, a1, a0);
    return {a3, a2, a1, a0};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    chk("rst_tx", tx_line, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_gid", grant_id, 0);
    rst_n = 1'b1;
  endtask
  task automatic wait_ack(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack == 0 && n < 100);
    chk("ack_seen", ack != 0, 1);
  endtask
  // called on the ack sample; returns on the sample where busy has just fallen
  task automatic check_frame(input logic [1:0] gid, input logic [6:0] w, input bit hold, input bit wd);
    logic [9:0] f, rx;
    f  = {1'b1, ^w, w, 1'b0};
    rx = '0;
    chk("ack", ack, 4'b1 << gid);
    chk("gid", grant_id, gid);
    if (!hold) req[gid] = 1'b0;
    for (int c = 0; c <= 40; c++) begin
      if (c > 0) @(negedge clk);
      if (c < 40) begin
        chk("tx", tx_line, f[c/4]);
        chk("busy", busy, 1);
        if (c > 0) chk("ack_once", ack, 0);
        if (c % 4 == 2) rx[c/4] = tx_line;
      end else begin
        chk("busy_fall", busy, 0);
        chk("tx_idle", tx_line, 1);
      end
      if (c == 5) data_in[int'(gid)*7 +: 7] = data_in[int'(gid)*7 +: 7] ^ 7'h7F;
      if (wd && c == 8) req[2] = 1'b1;
      if (wd && c == 12) req[2] = 1'b0;
    end
    chk("rx_start", rx[0], 0);
    chk("rx_word", rx[7:1], w);
    chk("rx_parity_err", ^rx[8:1], 0);
    chk("rx_stop", rx[9], 1);
  endtask
  initial begin
    int n;
    tbl[0]  = '{1'b1, 4'b0001, pack(0, 0, 0, 7'h55), 2'd0, 7'h55};
    tbl[1]  = '{1'b0, 4'b0001, pack(0, 0, 0, 7'h7F), 2'd0, 7'h7F};
    tbl[2]  = '{1'b0, 4'b0001, pack(0, 0, 0, 7'h00), 2'd0, 7'h00};
    tbl[3]  = '{1'b1, 4'b1111, pack(7'h44, 7'h33, 7'h22, 7'h11), 2'd0, 7'h11};
    tbl[4]  = '{1'b0, 4'b0000, pack(7'h44, 7'h33, 7'h22, 7'h11), 2'd1, 7'h22};
    tbl[5]  = '{1'b0, 4'b0000, pack(7'h44, 7'h33, 7'h22, 7'h11), 2'd2, 7'h33};
    tbl[6]  = '{1'b0, 4'b0000, pack(7'h44, 7'h33, 7'h22, 7'h11), 2'd3, 7'h44};
    tbl[7]  = '{1'b0, 4'b0101, pack(0, 7'h5B, 0, 7'h0A), 2'd0, 7'h0A};
    tbl[8]  = '{1'b0, 4'b0000, pack(0, 7'h5B, 0, 7'h0A), 2'd2, 7'h5B};
    tbl[9]  = '{1'b0, 4'b0011, pack(0, 0, 7'h02, 7'h01), 2'd0, 7'h01};
    tbl[10] = '{1'b0, 4'b0000, pack(0, 0, 7'h02, 7'h01), 2'd1, 7'h02};
    @(negedge clk);
    for (int v = 0; v < 11; v++) begin
      if (tbl[v].rst) do_reset();
      req     = req | tbl[v].raise;
      data_in = tbl[v].data;
      wait_ack(n);
      check_frame(tbl[v].gid, tbl[v].word, 1'b0, 1'b0);
    end
    // back-to-back on requester 1 with a withdrawn request from requester 2
    data_in = pack(0, 7'h15, 7'h63, 0);
    req     = 4'b0010;
    wait_ack(n);
    check_frame(2'd1, 7'h63, 1'b1, 1'b1);
    wait_ack(n);
    chk("b2b_gap", n, 1);
    check_frame(2'd1, 7'h63 ^ 7'h7F, 1'b0, 1'b0);
    repeat (12) begin
      @(negedge clk);
      chk("no_ack_wd", ack, 0);
      chk("idle_busy", busy, 0);
    end
    // reset during DATA bit 3
    data_in = pack(0, 0, 0, 7'h2A);
    req     = 4'b0001;
    wait_ack(n);
    req[0] = 1'b0;
    repeat (17) @(negedge clk);
    chk("pre_rst_bit3", tx_line, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_tx", tx_line, 1);
    chk("async_busy", busy, 0);
    chk("async_gid", grant_id, 0);
    @(negedge clk);
    rst_n   = 1'b1;
    data_in = pack(7'h3C, 0, 0, 0);
    req     = 4'b1000;
    wait_ack(n);
    check_frame(2'd3, 7'h3C, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
